// File: rtl/rand_pkg.sv
// Constants shared by the 32-bit random generator and the blocks that consume
// its samples.
package rand_pkg;

  localparam int unsigned RAND_W = 32;

  // Ceiling log2, with a minimum of 0; used to size pointers and occupancy counts.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rand_fifo_core.sv
// Parameterised circular buffer with push/pop, occupancy count and full/empty
// flags. A pop is ignored while empty. Storage is not cleared on reset.
module rand_fifo_core
  import rand_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [clog2(DEPTH):0]    count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rand_bounded_fifo.sv
// Prefetching consumer of a 32-bit random generator: keeps requests flowing,
// scales each sample into [0, BOUND) by multiply-high and buffers the results.
module rand_bounded_fifo
  import rand_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BOUND = 10,
  parameter int unsigned OUT_W = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic                  RAND_REQ,
  input  logic [RAND_W-1:0]     RAND_IN,
  output logic [OUT_W-1:0]      OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_DEQ,
  output logic                  FULL,
  output logic [clog2(DEPTH):0] COUNT
);

  localparam int unsigned CNT_W  = clog2(DEPTH) + 1;
  localparam int unsigned PROD_W = RAND_W + OUT_W;

  logic              inflight_q, inflight_d;
  logic [CNT_W:0]    pending;
  logic [PROD_W-1:0] product;
  logic [OUT_W-1:0]  scaled;
  logic [RAND_W-1:0] frac_unused;
  logic [OUT_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  // A same-cycle dequeue is not credited, so an accepted sample always has room.
  always_comb begin
    pending    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    RAND_REQ   = !RESET && (pending < (CNT_W + 1)'(DEPTH));
    inflight_d = RAND_REQ;
  end

  always_comb begin
    product = {{OUT_W{1'b0}}, RAND_IN} * PROD_W'(BOUND);
    {scaled, frac_unused} = product;
  end

  always_ff @(posedge CLK) begin
    if (RESET) inflight_q <= 1'b0;
    else       inflight_q <= inflight_d;
  end

  rand_fifo_core #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (inflight_q),
    .push_data (scaled),
    .pop       (OUT_DEQ),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign OUT_VALID = !RESET && !fifo_empty;
  assign OUT_DATA  = OUT_VALID ? fifo_head : '0;
  assign FULL      = !RESET && fifo_full;
  assign COUNT     = RESET ? '0 : fifo_count;

endmodule

// File: tb/tb_rand_bounded_fifo.sv
// Bench for rand_bounded_fifo: generator model plus a queue-based reference
// compared every cycle, with directed literal checks and a random phase.
module tb_rand_bounded_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned BOUND = 10;
  localparam int unsigned OUT_W = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RAND_REQ;
  logic [31:0] RAND_IN = '0;
  logic [3:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_DEQ;
  logic        FULL;
  logic [2:0]  COUNT;

  int unsigned checks = 0;
  int unsigned failures = 0;
  bit          cmp_en = 1'b0;

  logic [31:0] fq[$];
  int unsigned m_q[$];
  bit          m_infl = 1'b0;

  always #5 CLK = ~CLK;

  rand_bounded_fifo #(
    .DEPTH (DEPTH),
    .BOUND (BOUND),
    .OUT_W (OUT_W)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RAND_REQ  (RAND_REQ),
    .RAND_IN   (RAND_IN),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_DEQ   (OUT_DEQ),
    .FULL      (FULL),
    .COUNT     (COUNT)
  );

  function automatic int unsigned scale(input logic [31:0] r);
    logic [63:0] p;
    p = 64'(r) * 64'(BOUND);
    return int'(p[63:32]);
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Generator: value requested in cycle t appears on RAND_IN from cycle t+1.
  always @(posedge CLK) begin
    if (RAND_REQ) begin
      if (fq.size() > 0) RAND_IN <= fq.pop_front();
      else               RAND_IN <= $urandom();
    end
  end

  // Reference: a queue of scaled values plus one outstanding-request flag.
  always @(posedge CLK) begin
    int unsigned sz;
    bit          req;
    if (RESET) begin
      m_q.delete();
      m_infl = 1'b0;
    end else begin
      sz  = m_q.size();
      req = (sz + int'(m_infl)) < DEPTH;
      if (OUT_DEQ && sz > 0) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(scale(RAND_IN));
      m_infl = req;
    end
  end

  always @(negedge CLK) begin
    int unsigned sz;
    bit          ev;
    if (cmp_en) begin
      sz = m_q.size();
      ev = !RESET && sz > 0;
      chk("out_valid", OUT_VALID, ev);
      chk("out_data", OUT_DATA, ev ? m_q[0] : 0);
      chk("full", FULL, !RESET && sz == DEPTH);
      chk("count", COUNT, RESET ? 0 : sz);
      chk("rand_req", RAND_REQ, !RESET && (sz + int'(m_infl)) < DEPTH);
    end
  end

  initial begin
    int unsigned drain_exp[5];
    bit          found;
    RESET   = 1'b1;
    OUT_DEQ = 1'b0;
    fq.push_back(32'h8000_0000);
    fq.push_back(32'h0000_0000);
    fq.push_back(32'hFFFF_FFFF);
    fq.push_back(32'h1999_9999);
    fq.push_back(32'h1999_999A);
    drain_exp = '{5, 0, 9, 0, 1};

    repeat (3) tick();
    cmp_en = 1'b1;
    chk("reset_count", COUNT, 0);
    chk("reset_req", RAND_REQ, 0);

    // Release: c0
    tick();
    RESET = 1'b0;
    #1;
    chk("c0_req", RAND_REQ, 1);
    chk("c0_valid", OUT_VALID, 0);
    tick();                                  // c1
    tick();                                  // c2
    chk("c2_valid", OUT_VALID, 1);
    chk("c2_data", OUT_DATA, 5);
    tick();                                  // c3
    chk("c3_req", RAND_REQ, 1);
    tick();                                  // c4
    chk("c4_req", RAND_REQ, 0);
    chk("c4_full", FULL, 0);
    tick();                                  // c5
    chk("c5_full", FULL, 1);
    chk("c5_count", COUNT, 4);
    for (int i = 6; i < 10; i++) begin
      tick();
      chk("hold_req", RAND_REQ, 0);
      chk("hold_count", COUNT, 4);
    end

    // Drain from full with continuous dequeue.
    for (int i = 0; i < 5; i++) begin
      tick();
      OUT_DEQ = 1'b1;
      #1;
      chk("drain_data", OUT_DATA, drain_exp[i]);
      chk("drain_valid", OUT_VALID, 1);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stream_valid", OUT_VALID, 1);
    end

    // Reset with COUNT=3 and a sample in flight.
    tick();
    OUT_DEQ = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_q.size() == 3 && m_infl) found = 1'b1;
    end
    chk("rst_setup_found", found, 1);
    chk("rst_setup_count", COUNT, 3);
    RESET = 1'b1;
    #1;
    chk("rst_hi_count", COUNT, 0);
    chk("rst_hi_valid", OUT_VALID, 0);
    tick();                                  // c0 with empty pop
    RESET   = 1'b0;
    OUT_DEQ = 1'b1;
    #1;
    chk("rel_count", COUNT, 0);
    chk("rel_valid", OUT_VALID, 0);
    chk("rel_req", RAND_REQ, 1);
    tick();                                  // c1
    chk("rel_c1_valid", OUT_VALID, 0);
    tick();                                  // c2
    OUT_DEQ = 1'b0;
    #1;
    chk("rel_c2_valid", OUT_VALID, 1);
    chk("rel_c2_count", COUNT, 1);
    tick();                                  // c3: push+pop at COUNT=2
    chk("pp_before_count", COUNT, 2);
    OUT_DEQ = 1'b1;
    tick();
    OUT_DEQ = 1'b0;
    #1;
    chk("pp_after_count", COUNT, 2);

    // Random phase with occasional resets.
    for (int i = 0; i < 500; i++) begin
      tick();
      OUT_DEQ = ($urandom_range(0, 3) != 0);
      RESET   = ($urandom_range(0, 63) == 0);
    end
    tick();
    RESET   = 1'b0;
    OUT_DEQ = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_bounded_fifo.md
# rand_bounded_fifo

Prefetching consumer stage placed directly downstream of the 32-bit random generator (`mkRand32Normal`-style: request in cycle t, new value on its output from cycle t+1). It keeps the generator busy, scales each 32-bit sample into the range [0, BOUND) by multiply-high, and buffers the results in a small FIFO. Consumers get a bounded random number every cycle through a valid/dequeue handshake without ever waiting on the generator.

## Interface

- DEPTH, 4: FIFO entries; power of two, ≥2.
- BOUND, 10: exclusive upper bound of output values; 2..2^OUT_W.
- OUT_W, 4: output width; ≥ ceil(log2(BOUND)).
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- RAND_REQ  out  1  drives the generator's REQ_WRITE.
- RAND_IN  in  32  generator's RESP_READ.
- OUT_DATA  out  OUT_W  head entry; 0 when empty.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_DEQ  in  1  pop head this cycle; ignored when OUT_VALID=0.
- FULL  out  1  count == DEPTH.
- COUNT  out  clog2(DEPTH)+1  current occupancy.

## Operation

- State: FIFO storage (DEPTH × OUT_W), read/write pointers (wrap modulo DEPTH), count, 1-bit `inflight`.
- Request rule: RAND_REQ = !RESET && (count + inflight < DEPTH). A dequeue in the same cycle is not credited, so a push can never overflow.
- Each edge: inflight <= RAND_REQ. If inflight was 1, RAND_IN is the fresh sample and is pushed.
- Scaling: product = RAND_IN × BOUND, width 32+OUT_W; pushed value = product[32+OUT_W-1:32]. The result is always < BOUND. There is no divider and no rejection.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pop when empty: no effect. Pointers and count are unchanged.
- Reset: count, pointers, and inflight go to 0. OUT_VALID=0, OUT_DATA=0, FULL=0, COUNT=0, RAND_REQ=0 while RESET is high. A sample whose request was issued in the cycle before reset asserted is discarded, because inflight is cleared. FIFO contents are not cleared, but they are invisible because OUT_DATA is gated by OUT_VALID.

## Timing

- Release: RESET low in cycle c0. RAND_REQ=1 in c0. Sample valid on RAND_IN in c1, pushed at the end of c1. OUT_VALID=1 in c2.
- Throughput: one push per cycle sustained. With no dequeues, FULL rises DEPTH+1 cycles after release. RAND_REQ drops in the cycle where count+inflight reaches DEPTH.
- Refill: a pop from FULL with no inflight sample gives RAND_REQ=1 in the next cycle and a push one cycle later. Full-to-full refill latency is 2 cycles.
- Continuous dequeue at 1/cycle from steady state keeps OUT_VALID=1. Request and push pipelining hides the 2-cycle refill because count+inflight < DEPTH is re-evaluated every cycle.
- OUT_DATA, OUT_VALID, FULL, and COUNT are registered-state outputs: no combinational path from OUT_DEQ or RAND_IN.
- RAND_REQ is combinational from count, inflight, and RESET only.

## Structure

- Shared header/package `rand_pkg`: RAND_W=32 and the clog2 function used for pointer and COUNT widths. The upstream generator uses the same constants.
- One sub-module: `rand_fifo_core`, a parameterised circular buffer (WIDTH, DEPTH) with push/pop/count/full/empty. The top level holds inflight tracking, the request rule, and the multiply-high scaler.
- The top level instantiates the generator only in the bench, not inside this block.

## Test plan

- Reset release, bench generator returns 0x80000000 → RAND_REQ=1 in c0, OUT_VALID=1 in c2, OUT_DATA=5.
- Scaling corners: RAND_IN 0x00000000 → 0; 0xFFFFFFFF → 9; 0x19999999 → 0; 0x1999999A → 1.
- No dequeue for 10 cycles, DEPTH=4 → FULL=1 and COUNT=4 from c5. RAND_REQ=0 from c4 onward. No fifth push, and FIFO order is preserved on drain.
- From FULL, hold OUT_DEQ=1 for 20 cycles → OUT_VALID never drops after the first refill. Values come out in generator order with no duplicates or skips.
- Assert RESET for one cycle while inflight=1 and COUNT=3 → next cycle COUNT=0 and OUT_VALID=0. The inflight sample is never output, and the refill restarts per the c0/c2 timing.
- OUT_DEQ=1 while empty, and simultaneous push+pop at COUNT=2 → the empty pop has no effect; the push+pop keeps COUNT=2 and advances the head.
